// File: rtl/carbonio_timer_regs.sv
// CarbonIO timer register front-end: bus decode, strobes, tick snapshot, irq pending.
// One request per two cycles (accept in IDLE, ack in RESP); bus_req is ignored while in RESP.
module carbonio_timer_regs #(
  parameter int NUM_TIMERS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       bus_req,
  input  logic                       bus_we,
  input  logic [7:0]                 bus_addr,
  input  logic [31:0]                bus_wdata,
  output logic                       bus_ack,
  output logic                       bus_err,
  output logic [31:0]                bus_rdata,
  input  logic [63:0]                tick_counter,
  input  logic [NUM_TIMERS*32-1:0]   load_q,
  input  logic [NUM_TIMERS*32-1:0]   ctrl_q,
  input  logic [NUM_TIMERS*32-1:0]   value_q,
  input  logic [NUM_TIMERS-1:0]      expired_q,
  input  logic [NUM_TIMERS-1:0]      expired_pulse,
  output logic [NUM_TIMERS-1:0]      load_we,
  output logic [NUM_TIMERS-1:0]      ctrl_we,
  output logic [NUM_TIMERS-1:0]      status_clr,
  output logic [NUM_TIMERS*32-1:0]   load_wdata,
  output logic [NUM_TIMERS*32-1:0]   ctrl_wdata,
  output logic                       irq
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    we_q;
  logic [5:0]              word_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    err_q;
  logic [31:0]             rd_data;
  logic                    acc_err;
  logic                    wr;
  logic [NUM_TIMERS-1:0]   irq_pend, irq_en, pend_d, en_d, pend_clr;
  logic [31:0]             tick_hi_snap;
  logic                    irq_q;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    bus_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus_req) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data and address validity are decoded from the live bus in the accept cycle.
  always_comb begin
    rd_data = '0;
    acc_err = 1'b0;
    if (bus_addr[7:4] == 4'h0) begin
      case (bus_addr[3:2])
        2'd0:    rd_data = tick_counter[31:0];
        2'd1:    rd_data = tick_hi_snap;
        2'd2:    rd_data = 32'(irq_pend);
        default: rd_data = 32'(irq_en);
      endcase
    end else begin
      acc_err = 1'b1;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (bus_addr[7:4] == 4'(i + 1)) begin
          acc_err = 1'b0;
          case (bus_addr[3:2])
            2'd0:    rd_data = load_q[i*32 +: 32];
            2'd1:    rd_data = ctrl_q[i*32 +: 32];
            2'd2:    rd_data = value_q[i*32 +: 32];
            default: rd_data = {31'b0, expired_q[i]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      tick_hi_snap <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus_we;
        word_q  <= bus_addr[7:2];
        wdata_q <= bus_wdata;
        rdata_q <= bus_we ? 32'd0 : rd_data;
        err_q   <= acc_err;
        if (!bus_we && bus_addr[7:2] == 6'd0) tick_hi_snap <= tick_counter[63:32];
      end else begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus_rdata = rdata_q;
  assign bus_err   = err_q;

  // Side effects of a write land only in the RESP cycle, and never for unmapped addresses.
  assign wr = (state_q == RESP) && we_q && !err_q;

  always_comb begin
    load_we    = '0;
    ctrl_we    = '0;
    status_clr = '0;
    if (wr) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (word_q[5:2] == 4'(i + 1)) begin
          case (word_q[1:0])
            2'd0:    load_we[i]    = 1'b1;
            2'd1:    ctrl_we[i]    = 1'b1;
            2'd3:    status_clr[i] = wdata_q[0];
            default: ;
          endcase
        end
      end
    end
  end

  assign load_wdata = {NUM_TIMERS{wdata_q}};
  assign ctrl_wdata = {NUM_TIMERS{wdata_q}};

  // A new expiry in the same cycle as its W1C keeps the bit set.
  assign pend_clr = (wr && word_q == 6'd2) ? wdata_q[NUM_TIMERS-1:0] : '0;
  assign pend_d   = (irq_pend & ~pend_clr) | expired_pulse;
  assign en_d     = (wr && word_q == 6'd3) ? wdata_q[NUM_TIMERS-1:0] : irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_pend <= '0;
      irq_en   <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_pend <= pend_d;
      irq_en   <= en_d;
      irq_q    <= |(pend_d & en_d);
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_carbonio_timer_regs.sv
// Directed bench for carbonio_timer_regs with a response scoreboard.
module tb_carbonio_timer_regs;

  logic        clk;
  logic        rst_n;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic [63:0] tick_counter;
  logic [63:0] load_q, ctrl_q, value_q;
  logic [1:0]  expired_q, expired_pulse;
  logic [1:0]  load_we, ctrl_we, status_clr;
  logic [63:0] load_wdata, ctrl_wdata;
  logic        irq;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [1:0]  obs_load_we, obs_ctrl_we, obs_clr;
  logic [63:0] obs_load_wdata, obs_ctrl_wdata;

  carbonio_timer_regs #(.NUM_TIMERS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_err       (bus_err),
    .bus_rdata     (bus_rdata),
    .tick_counter  (tick_counter),
    .load_q        (load_q),
    .ctrl_q        (ctrl_q),
    .value_q       (value_q),
    .expired_q     (expired_q),
    .expired_pulse (expired_pulse),
    .load_we       (load_we),
    .ctrl_we       (ctrl_we),
    .status_clr    (status_clr),
    .load_wdata    (load_wdata),
    .ctrl_wdata    (ctrl_wdata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One bus transfer: accept cycle, then RESP (compared against the scoreboard), then one idle cycle.
  task automatic xfer(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input logic [1:0] pulse_resp);
    resp_t e;
    resp_t got;
    int    cnt;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    chk("ack_before_accept", {63'b0, bus_ack}, 64'd0);
    bus_req   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      bus_req = 1'b0;
    end while (!bus_ack && cnt < 4);
    got = exp_q.pop_front();
    if (!bus_ack) begin
      total++;
      bad++;
      $error("FAIL ack_timeout addr=%0h observed=no_ack expected=ack", addr);
    end else begin
      chk("ack_latency", 64'(cnt), 64'd1);
      chk("rdata", {32'b0, bus_rdata}, {32'b0, got.rdata});
      chk("err", {63'b0, bus_err}, {63'b0, got.err});
    end
    obs_load_we    = load_we;
    obs_ctrl_we    = ctrl_we;
    obs_clr        = status_clr;
    obs_load_wdata = load_wdata;
    obs_ctrl_wdata = ctrl_wdata;
    expired_pulse  = pulse_resp;
    @(negedge clk);
    expired_pulse = 2'b00;
    chk("idle_quiet", {58'b0, load_we, ctrl_we, status_clr}, 64'd0);
    chk("idle_ack", {63'b0, bus_ack}, 64'd0);
  endtask

  task automatic pulse(input logic [1:0] p);
    @(negedge clk);
    expired_pulse = p;
    @(negedge clk);
    expired_pulse = 2'b00;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus_req       = 1'b0;
    bus_we        = 1'b0;
    bus_addr      = '0;
    bus_wdata     = '0;
    tick_counter  = '0;
    load_q        = '0;
    ctrl_q        = '0;
    value_q       = '0;
    expired_q     = '0;
    expired_pulse = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {63'b0, bus_ack}, 64'd0);
    chk("rst_irq", {63'b0, irq}, 64'd0);
    chk("rst_err_rdata", {31'b0, bus_err, bus_rdata}, 64'd0);
    chk("rst_strobes", {58'b0, load_we, ctrl_we, status_clr}, 64'd0);
    rst_n = 1'b1;

    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, 2'b00);

    xfer(1'b1, 8'h10, 32'h0000_0100, 32'h0, 1'b0, 2'b00);
    chk("load_we", {62'b0, obs_load_we}, 64'd1);
    chk("load_wdata0", {32'b0, obs_load_wdata[31:0]}, 64'h100);
    chk("load_other", {60'b0, obs_ctrl_we, obs_clr}, 64'd0);
    load_q[31:0] = 32'h0000_0100;
    xfer(1'b0, 8'h10, 32'h0, 32'h0000_0100, 1'b0, 2'b00);

    tick_counter = 64'h0000_0001_FFFF_FFFF;
    xfer(1'b0, 8'h00, 32'h0, 32'hFFFF_FFFF, 1'b0, 2'b00);
    tick_counter = 64'h0000_0002_0000_0005;
    xfer(1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 2'b00);

    xfer(1'b1, 8'h0C, 32'h3, 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 8'h0C, 32'h0, 32'h3, 1'b0, 2'b00);
    @(negedge clk);
    chk("irq_before_pulse", {63'b0, irq}, 64'd0);
    expired_pulse = 2'b10;
    @(negedge clk);
    expired_pulse = 2'b00;
    chk("irq_after_pulse", {63'b0, irq}, 64'd1);
    xfer(1'b0, 8'h08, 32'h0, 32'h2, 1'b0, 2'b00);
    xfer(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, 2'b00);
    chk("irq_after_w1c", {63'b0, irq}, 64'd0);
    xfer(1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 2'b00);

    pulse(2'b10);
    xfer(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, 2'b10);
    chk("irq_set_wins", {63'b0, irq}, 64'd1);
    xfer(1'b0, 8'h08, 32'h0, 32'h2, 1'b0, 2'b00);
    xfer(1'b1, 8'h08, 32'h2, 32'h0, 1'b0, 2'b00);
    chk("irq_cleared", {63'b0, irq}, 64'd0);

    xfer(1'b1, 8'h0C, 32'h0, 32'h0, 1'b0, 2'b00);
    pulse(2'b01);
    chk("irq_masked", {63'b0, irq}, 64'd0);
    xfer(1'b0, 8'h08, 32'h0, 32'h1, 1'b0, 2'b00);
    xfer(1'b1, 8'h0C, 32'h1, 32'h0, 1'b0, 2'b00);
    chk("irq_on_enable", {63'b0, irq}, 64'd1);
    xfer(1'b1, 8'h0C, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("irq_on_disable", {63'b0, irq}, 64'd0);
    xfer(1'b1, 8'h08, 32'h1, 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 2'b00);

    xfer(1'b1, 8'h2C, 32'h1, 32'h0, 1'b0, 2'b00);
    chk("status_clr1", {62'b0, obs_clr}, 64'd2);
    chk("status_clr1_other", {60'b0, obs_load_we, obs_ctrl_we}, 64'd0);
    xfer(1'b1, 8'h2C, 32'h0, 32'h0, 1'b0, 2'b00);
    chk("status_clr0", {58'b0, obs_load_we, obs_ctrl_we, obs_clr}, 64'd0);
    xfer(1'b1, 8'h18, 32'h5, 32'h0, 1'b0, 2'b00);
    chk("value_wr_quiet", {58'b0, obs_load_we, obs_ctrl_we, obs_clr}, 64'd0);
    xfer(1'b1, 8'h24, 32'h4, 32'h0, 1'b0, 2'b00);
    chk("ctrl_we1", {60'b0, obs_load_we, obs_ctrl_we}, 64'd2);
    chk("ctrl_wdata1", {32'b0, obs_ctrl_wdata[63:32]}, 64'h4);

    expired_q      = 2'b10;
    value_q[31:0]  = 32'h0000_DEAD;
    ctrl_q[63:32]  = 32'h1234_5678;
    xfer(1'b0, 8'h2C, 32'h0, 32'h1, 1'b0, 2'b00);
    xfer(1'b0, 8'h1C, 32'h0, 32'h0, 1'b0, 2'b00);
    xfer(1'b0, 8'h18, 32'h0, 32'h0000_DEAD, 1'b0, 2'b00);
    xfer(1'b0, 8'h24, 32'h0, 32'h1234_5678, 1'b0, 2'b00);

    xfer(1'b0, 8'h30, 32'h0, 32'h0, 1'b1, 2'b00);
    xfer(1'b1, 8'h30, 32'h1, 32'h0, 1'b1, 2'b00);
    chk("unmapped_wr_quiet", {58'b0, obs_load_we, obs_ctrl_we, obs_clr}, 64'd0);

    @(negedge clk);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 8'h0C;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("held_req_ack", {63'b0, bus_ack}, (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    bus_req = 1'b0;
    @(negedge clk);

    xfer(1'b1, 8'h0C, 32'h3, 32'h0, 1'b0, 2'b00);
    @(negedge clk);
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 8'h10;
    bus_wdata = 32'h55;
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    bus_req = 1'b0;
    @(negedge clk);
    chk("midrst_ack", {63'b0, bus_ack}, 64'd0);
    chk("midrst_strobe", {58'b0, load_we, ctrl_we, status_clr}, 64'd0);
    rst_n = 1'b1;
    xfer(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
